// File: rtl/vz_saver_if.sv
// Bus bundle for the VZ saver: RAM read port (one-cycle latency) and the
// byte-stream upload path towards the host.
interface vz_saver_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [7:0]  out_data;
  logic [15:0] out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  // Saver side: issues RAM reads, produces the stream.
  modport master (
    output mem_addr, mem_rd, out_data, out_addr, out_valid, out_last,
    input  mem_data, out_ready
  );

  // Memory/host side: returns RAM data, consumes the stream.
  modport slave (
    input  mem_addr, mem_rd, out_data, out_addr, out_valid, out_last,
    output mem_data, out_ready
  );
endinterface

// File: rtl/vz_saver.sv
// VZ saver: serialises a RAM region into a .VZ byte stream (24-byte header
// plus body). BASIC saves fetch start/end from the ROM program pointers in
// RAM, machine-code saves take them from the mc_* ports. All outputs are
// registered; save_abort returns to IDLE on the next edge.
module vz_saver #(
  parameter int NAME_LEN = 16
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          save_start,
  input  logic          save_abort,
  input  logic [7:0]    mode,
  input  logic [15:0]   mc_start,
  input  logic [15:0]   mc_end,
  input  logic [127:0]  name,
  vz_saver_if.master    bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [3:0] {
    S_IDLE, S_VAR_RD, S_VAR_LAT, S_CHECK, S_HDR,
    S_BODY_RD, S_BODY_LAT, S_BODY_OUT, S_FIN
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    var_idx_r, var_idx_s;
  logic [15:0]   start_r, start_s;
  logic [15:0]   end_r, end_s;
  logic [15:0]   cur_r, cur_s;
  logic [15:0]   rem_r, rem_s;
  logic [7:0]    mode_r, mode_s;
  logic [127:0]  name_r, name_s;
  logic [15:0]   mem_addr_r, mem_addr_s;
  logic          mem_rd_r, mem_rd_s;
  logic [7:0]    out_data_r, out_data_s;
  logic [15:0]   out_addr_r, out_addr_s;
  logic          out_valid_r, out_valid_s;
  logic          out_last_r, out_last_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          err_r, err_s;
  logic [4:0]    hdr_next_s;

  // ROM pointer locations: program start lo/hi, then program end lo/hi.
  function automatic logic [15:0] var_addr(input logic [1:0] idx);
    logic [15:0] a;
    case (idx)
      2'd0:    a = 16'h78A4;
      2'd1:    a = 16'h78A5;
      2'd2:    a = 16'h78F9;
      2'd3:    a = 16'h78FA;
      default: a = 16'h0000;
    endcase
    return a;
  endfunction

  // Header byte at file offset idx (0..23).
  function automatic logic [7:0] hdr_byte(input logic [4:0] idx, input logic [127:0] nm,
                                          input logic [7:0] md, input logic [15:0] st);
    logic [7:0] b;
    logic [4:0] nidx;
    logic [6:0] sh;
    b    = 8'h00;
    nidx = idx - 5'd4;
    sh   = {nidx[3:0], 3'b000};
    case (idx)
      5'd0, 5'd1: b = 8'h20;
      5'd21:      b = md;
      5'd22:      b = st[7:0];
      5'd23:      b = st[15:8];
      default: begin
        if ((idx >= 5'd4) && (idx <= 5'd19) && (32'(nidx) < NAME_LEN)) begin
          b = nm[sh +: 8];
        end else begin
          b = 8'h00;
        end
      end
    endcase
    return b;
  endfunction

  // Next-state and next-output computation for the save sequencer.
  always_comb begin
    state_s     = state_r;
    var_idx_s   = var_idx_r;
    start_s     = start_r;
    end_s       = end_r;
    cur_s       = cur_r;
    rem_s       = rem_r;
    mode_s      = mode_r;
    name_s      = name_r;
    mem_addr_s  = mem_addr_r;
    mem_rd_s    = mem_rd_r;
    out_data_s  = out_data_r;
    out_addr_s  = out_addr_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    hdr_next_s  = out_addr_r[4:0] + 5'd1;

    if (save_abort) begin
      state_s     = S_IDLE;
      out_valid_s = 1'b0;
      out_last_s  = 1'b0;
      mem_rd_s    = 1'b0;
      busy_s      = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (save_start) begin
            if (mode == 8'hF0) begin
              state_s    = S_VAR_RD;
              busy_s     = 1'b1;
              mode_s     = mode;
              name_s     = name;
              var_idx_s  = 2'd0;
              mem_addr_s = var_addr(2'd0);
              mem_rd_s   = 1'b1;
            end else if (mode == 8'hF1) begin
              state_s = S_CHECK;
              busy_s  = 1'b1;
              mode_s  = mode;
              name_s  = name;
              start_s = mc_start;
              end_s   = mc_end;
            end else begin
              err_s = 1'b1;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_VAR_RD: begin
          mem_rd_s = 1'b0;
          state_s  = S_VAR_LAT;
        end
        S_VAR_LAT: begin
          case (var_idx_r)
            2'd0:    start_s[7:0]  = bus.mem_data;
            2'd1:    start_s[15:8] = bus.mem_data;
            2'd2:    end_s[7:0]    = bus.mem_data;
            2'd3:    end_s[15:8]   = bus.mem_data;
            default: start_s       = start_r;
          endcase
          if (var_idx_r == 2'd3) begin
            state_s = S_CHECK;
          end else begin
            var_idx_s  = var_idx_r + 2'd1;
            mem_addr_s = var_addr(var_idx_r + 2'd1);
            mem_rd_s   = 1'b1;
            state_s    = S_VAR_RD;
          end
        end
        S_CHECK: begin
          if (end_r < start_r) begin
            err_s   = 1'b1;
            busy_s  = 1'b0;
            state_s = S_IDLE;
          end else begin
            rem_s       = end_r - start_r;
            cur_s       = start_r;
            out_valid_s = 1'b1;
            out_addr_s  = 16'd0;
            out_data_s  = hdr_byte(5'd0, name_r, mode_r, start_r);
            out_last_s  = 1'b0;
            state_s     = S_HDR;
          end
        end
        S_HDR: begin
          if (bus.out_ready) begin
            out_addr_s = out_addr_r + 16'd1;
            if (out_addr_r == 16'd23) begin
              out_valid_s = 1'b0;
              out_last_s  = 1'b0;
              if (rem_r == 16'd0) begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_FIN;
              end else begin
                mem_addr_s = cur_r;
                mem_rd_s   = 1'b1;
                state_s    = S_BODY_RD;
              end
            end else begin
              out_data_s = hdr_byte(hdr_next_s, name_r, mode_r, start_r);
              out_last_s = (hdr_next_s == 5'd23) && (rem_r == 16'd0);
            end
          end else begin
            state_s = S_HDR;
          end
        end
        S_BODY_RD: begin
          mem_rd_s = 1'b0;
          state_s  = S_BODY_LAT;
        end
        S_BODY_LAT: begin
          out_data_s  = bus.mem_data;
          out_valid_s = 1'b1;
          out_last_s  = (rem_r == 16'd1);
          state_s     = S_BODY_OUT;
        end
        S_BODY_OUT: begin
          if (bus.out_ready) begin
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
            out_addr_s  = out_addr_r + 16'd1;
            rem_s       = rem_r - 16'd1;
            cur_s       = cur_r + 16'd1;
            if (rem_r == 16'd1) begin
              done_s  = 1'b1;
              busy_s  = 1'b0;
              state_s = S_FIN;
            end else begin
              mem_addr_s = cur_r + 16'd1;
              mem_rd_s   = 1'b1;
              state_s    = S_BODY_RD;
            end
          end else begin
            state_s = S_BODY_OUT;
          end
        end
        S_FIN: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s     = S_IDLE;
          out_valid_s = 1'b0;
          mem_rd_s    = 1'b0;
          busy_s      = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_r     <= S_IDLE;
      var_idx_r   <= 2'd0;
      start_r     <= 16'h0000;
      end_r       <= 16'h0000;
      cur_r       <= 16'h0000;
      rem_r       <= 16'h0000;
      mode_r      <= 8'h00;
      name_r      <= 128'd0;
      mem_addr_r  <= 16'h0000;
      mem_rd_r    <= 1'b0;
      out_data_r  <= 8'h00;
      out_addr_r  <= 16'h0000;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      var_idx_r   <= var_idx_s;
      start_r     <= start_s;
      end_r       <= end_s;
      cur_r       <= cur_s;
      rem_r       <= rem_s;
      mode_r      <= mode_s;
      name_r      <= name_s;
      mem_addr_r  <= mem_addr_s;
      mem_rd_r    <= mem_rd_s;
      out_data_r  <= out_data_s;
      out_addr_r  <= out_addr_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_rd    = mem_rd_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule

// File: tb/tb_vz_saver.sv
// Bench for vz_saver: RAM model with one-cycle read latency, stream monitor,
// and a reference that builds the expected .VZ file from the header rules
// and the RAM contents.
module tb_vz_saver;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         save_start = 1'b0;
  logic         save_abort = 1'b0;
  logic [7:0]   mode = 8'h00;
  logic [15:0]  mc_start = 16'h0000;
  logic [15:0]  mc_end = 16'h0000;
  logic [127:0] name = 128'd0;
  logic         busy, done, err;

  vz_saver_if bus ();

  vz_saver #(.NAME_LEN(16)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .save_start(save_start), .save_abort(save_abort),
    .mode(mode), .mc_start(mc_start), .mc_end(mc_end), .name(name),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  logic [7:0] got_data [$];
  logic [15:0] got_addr [$];
  logic       got_last [$];
  logic [15:0] rd_addr [$];
  int done_cnt = 0, err_cnt = 0, valid_cnt = 0, stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic [24:0] prev_val = 25'd0;
  int checks = 0, errors = 0;

  // RAM read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];
  end

  // Stream/strobe monitor: records accepted bytes, reads, pulses, stall stability.
  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got_data.push_back(bus.out_data);
      got_addr.push_back(bus.out_addr);
      got_last.push_back(bus.out_last);
    end
    if (bus.mem_rd) rd_addr.push_back(bus.mem_addr);
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (bus.out_valid) valid_cnt <= valid_cnt + 1;
    if (prev_stall && bus.out_valid && ({bus.out_last, bus.out_addr, bus.out_data} != prev_val))
      stall_bad <= stall_bad + 1;
    prev_stall <= bus.out_valid && !bus.out_ready && !save_abort;
    prev_val   <= {bus.out_last, bus.out_addr, bus.out_data};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {18'd0, bus.mem_addr, bus.mem_rd, bus.out_data, bus.out_addr,
            bus.out_valid, bus.out_last, busy, done, err};
  endfunction

  // One complete save against the reference; optional cycle-exact timing checks.
  task automatic run_save(input string tag, input logic [7:0] md, input logic [15:0] s,
                          input logic [15:0] e, input logic [127:0] nm,
                          input bit rnd_ready, input bit timed);
    logic [7:0]  exp_b [$];
    logic [15:0] exp_rd [$];
    logic [15:0] st, en;
    int cnt, first_v, base, rbase, dbase, sbase, len;
    bit fin;
    if (md == 8'hF0) begin
      st = {ram[16'h78A5], ram[16'h78A4]};
      en = {ram[16'h78FA], ram[16'h78F9]};
      exp_rd = '{16'h78A4, 16'h78A5, 16'h78F9, 16'h78FA};
    end else begin
      st = s;
      en = e;
    end
    len = int'(en) - int'(st);
    exp_b = '{8'h20, 8'h20, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) exp_b.push_back(nm[i*8 +: 8]);
    exp_b.push_back(8'h00);
    exp_b.push_back(md);
    exp_b.push_back(st[7:0]);
    exp_b.push_back(st[15:8]);
    for (int i = 0; i < len; i++) begin
      exp_b.push_back(ram[16'(int'(st) + i)]);
      exp_rd.push_back(16'(int'(st) + i));
    end
    base = got_data.size(); rbase = rd_addr.size(); dbase = done_cnt; sbase = stall_bad;
    @(negedge clk);
    save_start = 1'b1; mode = md; mc_start = s; mc_end = e; name = nm;
    bus.out_ready = 1'b1;
    @(posedge clk);
    cnt = 0; first_v = -1; fin = 1'b0;
    while (!fin && cnt < 3000) begin
      @(negedge clk);
      save_start = 1'b0;
      if (cnt == 0) check({tag, "_busy"}, busy, 1'b1);
      if (bus.out_valid && first_v < 0) first_v = cnt;
      if (done) fin = 1'b1;
      else begin
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        cnt++;
      end
    end
    check({tag, "_timeout"}, fin, 1'b1);
    if (timed) begin
      check({tag, "_first_valid"}, first_v, (md == 8'hF0) ? 9 : 1);
      check({tag, "_done_cycle"}, cnt, 25 + 3 * len + ((md == 8'hF0) ? 8 : 0));
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_once"}, done_cnt - dbase, 1);
    check({tag, "_idle"}, {busy, done, bus.out_valid}, 3'b000);
    check({tag, "_stall_stable"}, stall_bad - sbase, 0);
    check({tag, "_len"}, got_data.size() - base, exp_b.size());
    for (int i = 0; i < exp_b.size() && base + i < got_data.size(); i++)
      check({tag, "_byte"}, {got_last[base+i], got_addr[base+i], got_data[base+i]},
            {(i == exp_b.size() - 1), 16'(i), exp_b[i]});
    check({tag, "_rd_count"}, rd_addr.size() - rbase, exp_rd.size());
    for (int i = 0; i < exp_rd.size() && rbase + i < rd_addr.size(); i++)
      check({tag, "_rd_addr"}, rd_addr[rbase+i], exp_rd[i]);
  endtask

  // A request that must be rejected with a single err pulse and no stream.
  task automatic run_err(input string tag, input logic [7:0] md, input logic [15:0] s,
                         input logic [15:0] e);
    int ebase, vbase;
    ebase = err_cnt; vbase = valid_cnt;
    @(negedge clk);
    save_start = 1'b1; mode = md; mc_start = s; mc_end = e;
    @(negedge clk);
    save_start = 1'b0;
    repeat (12) @(negedge clk);
    check({tag, "_err_once"}, err_cnt - ebase, 1);
    check({tag, "_no_valid"}, valid_cnt - vbase, 0);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int k;
    bit found;
    logic [15:0] rs, rl;
    logic [127:0] nm0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    nm0 = 128'h0F0E0D0C0B0A09084F4C4C4548_5A5653;
    repeat (3) @(negedge clk);
    check("reset_values", out_vec(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    ram[16'h8000] = 8'hAA; ram[16'h8001] = 8'hBB; ram[16'h8002] = 8'hCC;
    run_save("mc", 8'hF1, 16'h8000, 16'h8003, nm0, 1'b0, 1'b1);

    ram[16'h78A4] = 8'hE9; ram[16'h78A5] = 8'h7A;
    ram[16'h78F9] = 8'h00; ram[16'h78FA] = 8'h7B;
    run_save("basic", 8'hF0, 16'h0000, 16'h0000, nm0, 1'b0, 1'b1);

    run_save("backpressure", 8'hF1, 16'h8000, 16'h8003, nm0, 1'b1, 1'b0);
    run_save("zero_len", 8'hF1, 16'h9000, 16'h9000, nm0, 1'b0, 1'b1);

    run_err("bad_mode", 8'h55, 16'h8000, 16'h8003);
    run_err("end_lt_start", 8'hF1, 16'h9000, 16'h8FFF);

    // Abort while body byte 1 (offset 25) is on offer.
    k = done_cnt;
    @(negedge clk);
    save_start = 1'b1; mode = 8'hF1; mc_start = 16'h8000; mc_end = 16'h8003;
    bus.out_ready = 1'b1;
    @(negedge clk);
    save_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.out_valid && bus.out_addr == 16'd25) found = 1'b1;
      else @(negedge clk);
    end
    check("abort_reach", found, 1'b1);
    save_abort = 1'b1;
    @(negedge clk);
    save_abort = 1'b0;
    check("abort_idle", {bus.out_valid, bus.mem_rd, busy}, 3'b000);
    save_start = 1'b1; save_abort = 1'b1;
    @(negedge clk);
    save_start = 1'b0; save_abort = 1'b0;
    check("start_with_abort", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - k, 0);
    run_save("restart", 8'hF1, 16'h8000, 16'h8003, nm0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of the header.
    @(negedge clk);
    save_start = 1'b1; mode = 8'hF1; mc_start = 16'h8000; mc_end = 16'h8003;
    @(negedge clk);
    save_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.out_valid && bus.out_addr == 16'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("reset_reach", found, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_header", out_vec(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Randomised saves in both modes.
    for (int r = 0; r < 6; r++) begin
      rs = 16'($urandom_range(0, 16'hFF00));
      rl = 16'($urandom_range(0, 15));
      if (r % 2 == 0) begin
        run_save("rand_mc", 8'hF1, rs, rs + rl,
                 {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
      end else begin
        rs = 16'($urandom_range(16'h8000, 16'hFF00));
        ram[16'h78A4] = rs[7:0]; ram[16'h78A5] = rs[15:8];
        ram[16'h78F9] = 8'(rs + rl); ram[16'h78FA] = 8'((rs + rl) >> 8);
        run_save("rand_basic", 8'hF0, 16'h0000, 16'h0000,
                 {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
